// File: rtl/alu_seq.sv
// ============================================================================
// Module   : alu_seq
// Brief    : Handshaked, registered ALU with a multi-cycle shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             overflow,
    output logic [2:0]       comp,
    output logic             slt,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADDU = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     x_q, x_d, y_q, y_d;
    logic [WIDTH-1:0]     result_q, result_d, result_hi_q, result_hi_d;
    logic                 carry_q, carry_d, overflow_q, overflow_d;
    logic [2:0]           comp_q, comp_d;
    logic                 slt_q, slt_d, err_q, err_d;

    logic [WIDTH:0]       w_sum, w_diff;
    logic [3:0]           w_flags, w_flags_lat;
    logic [2*WIDTH-1:0]   w_partial, w_acc_next;

    // Returns {comp, slt} for a signed comparison of a against b.
    function automatic logic [3:0] cmp_flags(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        if ($signed(a) < $signed(b)) begin
            return 4'b1001;
        end else if (a == b) begin
            return 4'b0100;
        end
        return 4'b0010;
    endfunction

    assign w_sum       = {1'b0, x} + {1'b0, y};
    assign w_diff      = {1'b0, x} - {1'b0, y};
    assign w_flags     = cmp_flags(x, y);
    assign w_flags_lat = cmp_flags(x_q, y_q);
    assign w_partial   = y_q[cnt_q] ? ({{WIDTH{1'b0}}, x_q} << cnt_q) : '0;
    assign w_acc_next  = acc_q + w_partial;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        x_d         = x_q;
        y_d         = y_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        comp_d      = comp_q;
        slt_d       = slt_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d = x;
                    y_d = y;
                    if (op == OP_MULU) begin
                        state_d = ST_MUL;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end else begin
                        state_d         = ST_DONE;
                        result_d        = '0;
                        result_hi_d     = '0;
                        carry_d         = 1'b0;
                        overflow_d      = 1'b0;
                        err_d           = 1'b0;
                        {comp_d, slt_d} = w_flags;
                        case (op)
                            OP_AND:  result_d = x & y;
                            OP_OR:   result_d = x | y;
                            OP_XOR:  result_d = x ^ y;
                            OP_ADDU: {carry_d, result_d} = w_sum;
                            OP_ADD: begin
                                {carry_d, result_d} = w_sum;
                                overflow_d = (x[WIDTH-1] == y[WIDTH-1]) &&
                                             (w_sum[WIDTH-1] != x[WIDTH-1]);
                            end
                            OP_SUB: begin
                                result_d   = w_diff[WIDTH-1:0];
                                carry_d    = ~w_diff[WIDTH];
                                overflow_d = (x[WIDTH-1] != y[WIDTH-1]) &&
                                             (w_diff[WIDTH-1] != x[WIDTH-1]);
                            end
                            OP_SLL:  result_d = x << y[SHW-1:0];
                            OP_SRL:  result_d = x >> y[SHW-1:0];
                            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, w_flags[0]};
                            default: begin
                                comp_d = 3'b000;
                                slt_d  = 1'b0;
                                err_d  = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ST_MUL: begin
                acc_d = w_acc_next;
                if (cnt_q == CNT_LAST) begin
                    state_d         = ST_DONE;
                    result_d        = w_acc_next[WIDTH-1:0];
                    result_hi_d     = w_acc_next[2*WIDTH-1:WIDTH];
                    carry_d         = 1'b0;
                    overflow_d      = 1'b0;
                    err_d           = 1'b0;
                    {comp_d, slt_d} = w_flags_lat;
                end else begin
                    cnt_d = cnt_q + SHW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            comp_q      <= 3'b000;
            slt_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            y_q         <= y_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            comp_q      <= comp_d;
            slt_q       <= slt_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign comp      = comp_q;
    assign slt       = slt_q;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Scoreboard bench for alu_seq at the default 16-bit width.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_seq;

    localparam int W = 16;

    logic         clock     = 1'b0;
    logic         clear     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   op        = 4'd0;
    logic [W-1:0] x         = '0;
    logic [W-1:0] y         = '0;
    logic         in_ready, out_valid, carry, overflow, slt, err;
    logic [W-1:0] result, result_hi;
    logic [2:0]   comp;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         c;
        logic         v;
        logic [2:0]   cmp;
        logic         lt;
        logic         e;
    } exp_t;

    exp_t sb_q[$];

    always #5 clock = ~clock;

    alu_seq #(.WIDTH(W)) dut (
        .clock     (clock),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .carry     (carry),
        .overflow  (overflow),
        .comp      (comp),
        .slt       (slt),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference model built from integer arithmetic and range tests.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        int          sa, sb, ua, ub, sres;
        logic [31:0] wide;
        logic [3:0]  sh;
        longint      p;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        sh = b[3:0];
        e.res = '0; e.hi = '0; e.c = 1'b0; e.v = 1'b0; e.e = 1'b0;
        e.lt  = (sa < sb);
        e.cmp = (sa < sb) ? 3'b100 : ((sa == sb) ? 3'b010 : 3'b001);
        case (o)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b1001: e.res = a ^ b;
            4'b0010, 4'b0011: begin
                wide  = ua + ub;
                e.res = wide[W-1:0];
                e.c   = (ua + ub) > 65535;
                if (o == 4'b0011) begin
                    sres = sa + sb;
                    e.v  = (sres > 32767) || (sres < -32768);
                end
            end
            4'b0100: begin
                e.res = a - b;
                e.c   = (ua >= ub);
                sres  = sa - sb;
                e.v   = (sres > 32767) || (sres < -32768);
            end
            4'b0101: e.res = a << sh;
            4'b0110: e.res = a >> sh;
            4'b0111: e.res = {15'd0, e.lt};
            4'b1000: begin
                p     = longint'(a) * longint'(b);
                wide  = p[31:0];
                e.res = wide[15:0];
                e.hi  = wide[31:16];
            end
            default: begin
                e.cmp = 3'b000;
                e.lt  = 1'b0;
                e.e   = 1'b1;
            end
        endcase
        return e;
    endfunction

    task automatic compare_outputs(input string tag, input exp_t e);
        check({tag, ".result"},    result,    e.res);
        check({tag, ".result_hi"}, result_hi, e.hi);
        check({tag, ".carry"},     carry,     e.c);
        check({tag, ".overflow"},  overflow,  e.v);
        check({tag, ".comp"},      comp,      e.cmp);
        check({tag, ".slt"},       slt,       e.lt);
        check({tag, ".err"},       err,       e.e);
    endtask

    // Issue one op, wait for its result, compare against the scoreboard,
    // optionally stall the consumer for a number of cycles, then complete.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit hold_valid, input int stall);
        exp_t e;
        int   k;
        bit   is_mul;
        is_mul = (o == 4'b1000);
        @(negedge clock);
        op        = o;
        x         = a;
        y         = b;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        check({tag, ".in_ready_idle"}, in_ready, 1);
        @(posedge clock);
        sb_q.push_back(model(o, a, b));
        #1;
        x = W'($urandom);
        y = W'($urandom);
        if (hold_valid) op = 4'b0001;
        else            in_valid = 1'b0;
        k = 1;
        while (!out_valid && k <= 40) begin
            if (is_mul) check({tag, ".in_ready_busy"}, in_ready, 0);
            @(posedge clock);
            #1;
            k++;
        end
        in_valid = 1'b0;
        // The product is registered on the WIDTH-th edge after the accept edge.
        check({tag, ".latency"}, k, is_mul ? W + 1 : 1);
        e = sb_q.pop_front();
        compare_outputs(tag, e);
        for (int i = 0; i < stall; i++) begin
            @(posedge clock);
            #1;
            check({tag, ".stall_valid"}, out_valid, 1);
            check({tag, ".stall_in_ready"}, in_ready, 0);
            compare_outputs({tag, ".stall"}, e);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check({tag, ".in_ready_after"}, in_ready, 1);
        check({tag, ".valid_after"}, out_valid, 0);
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clock);
        #1;
        check("rst.result", result, 0);
        check("rst.result_hi", result_hi, 0);
        check("rst.flags", {carry, overflow, comp, slt, err}, 0);
        check("rst.out_valid", out_valid, 0);
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        #1;
        check("rst.in_ready", in_ready, 1);

        run_op("and",   4'b0000, 16'h4BC5, 16'h4BC7, 1'b0, 0);
        run_op("add",   4'b0011, 16'h7FFF, 16'h0001, 1'b0, 0);
        run_op("addu",  4'b0010, 16'hFFFF, 16'h0001, 1'b0, 0);
        run_op("sub",   4'b0100, 16'h0003, 16'h0005, 1'b0, 0);
        run_op("subv",  4'b0100, 16'h8000, 16'h0001, 1'b0, 0);
        run_op("sll",   4'b0101, 16'h0001, 16'h0013, 1'b0, 0);
        run_op("sll0",  4'b0101, 16'hA5C3, 16'h0010, 1'b0, 0);
        run_op("srl",   4'b0110, 16'h8F00, 16'h0004, 1'b0, 0);
        run_op("slt",   4'b0111, 16'hFFFE, 16'h0002, 1'b0, 0);
        run_op("xor",   4'b1001, 16'h0FF0, 16'h3C3C, 1'b0, 0);
        run_op("eq",    4'b0001, 16'h1234, 16'h1234, 1'b0, 0);
        run_op("ill",   4'b1111, 16'h1234, 16'h0042, 1'b0, 0);
        run_op("mulu",  4'b1000, 16'hFFFF, 16'hFFFF, 1'b1, 0);
        run_op("mulr",  4'b1000, 16'h1234, 16'h00AB, 1'b0, 0);
        run_op("mulbp", 4'b1000, 16'hFFFF, 16'hFFFF, 1'b0, 5);
        for (int i = 0; i < 4; i++) begin
            run_op("rnd", 4'($urandom_range(0, 9)), W'($urandom), W'($urandom), 1'b0, 0);
        end

        // Abort a multiply with an asynchronous clear eight cycles in.
        @(negedge clock);
        op       = 4'b1000;
        x        = 16'h1234;
        y        = 16'h5678;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        clear = 1'b0;
        #1;
        check("abort.result", result, 0);
        check("abort.result_hi", result_hi, 0);
        check("abort.flags", {carry, overflow, comp, slt, err}, 0);
        check("abort.out_valid", out_valid, 0);
        @(negedge clock);
        @(negedge clock);
        clear = 1'b1;
        seen  = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (out_valid) seen++;
        end
        check("abort.no_output", seen, 0);
        run_op("or", 4'b0001, 16'h00F0, 16'h0F00, 1'b0, 0);

        check("sb.empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "simulation time limit reached");
    end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked ALU for the 16-bit datapath, the next generation of the processor's single-cycle arithmetic unit. It sits between the register-file read ports and the write-back/memory path. It accepts one operation per handshake and produces registered results and flags. Compared with the single-cycle unit it adds configurable width, shifts, XOR, subtract, an illegal-op flag, and an unsigned multiplier that iterates over several cycles.

## Interface
Parameters:
- WIDTH, 16, datapath width; power of two, minimum 4.
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- clear  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; high only in IDLE.
- op  in  4  opcode, decoded below.
- x, y  in  WIDTH  operands.
- out_valid  out  1  result registers hold a completed operation.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  primary result.
- result_hi  out  WIDTH  upper product half for MULU; 0 for every other op.
- carry  out  1  carry / no-borrow.
- overflow  out  1  signed overflow.
- comp  out  3  signed compare of x and y: 100 = lt, 010 = eq, 001 = gt.
- slt  out  1  signed x < y.
- err  out  1  illegal opcode.

## Operation
- Opcodes:
  - 0000 AND.
  - 0001 OR.
  - 0010 ADDU, {carry,result} = x+y, overflow 0.
  - 0011 ADD, signed; overflow = operands have the same sign and the result sign differs.
  - 0100 SUB, result = x−y; carry = 1 when x ≥ y unsigned; overflow = operands have different signs and the result sign differs from x.
  - 0101 SLL by y[SHW-1:0].
  - 0110 SRL (logical) by y[SHW-1:0].
  - 0111 SLT, result = {0…, slt}.
  - 1000 MULU, unsigned {result_hi,result} = x*y.
  - 1001 XOR.
  - Any other code: result 0, all flags 0, err 1.
- comp and slt are produced for every legal op, from the latched operands.
- carry is 0 except for ADDU, ADD and SUB. overflow is 0 except for ADD and SUB.
- The FSM has three states: IDLE, MUL, DONE.
  - IDLE: if in_valid, latch op, x and y. MULU goes to MUL with the counter cleared and the accumulator zeroed. Every other op computes its result into the output registers and goes to DONE.
  - MUL: shift-add, one multiplier bit per cycle, LSB first. The counter runs 0..WIDTH−1. When the counter reaches WIDTH−1, write the product, comp and slt, then go to DONE.
  - DONE: out_valid = 1. If out_ready, go to IDLE and drop out_valid. Otherwise hold every output stable.
- No request is accepted outside IDLE; in_valid is ignored there.
- Reset, asynchronous and at any time including mid-MUL:
  - State goes to IDLE and the counter and accumulator clear.
  - result, result_hi, carry, overflow, comp, slt, err and out_valid become 0.
  - in_ready is 1 once clear deasserts.
  - An aborted operation produces no output.

## Timing
- Accept edge: the edge where in_valid && in_ready.
- Non-MULU ops: out_valid rises on the edge after the accept edge (latency 1).
- MULU: out_valid rises WIDTH edges after the accept edge (16 cycles at default width).
- Handshake: completion occurs on the edge where out_valid && out_ready; in_ready rises on that same edge.
- The earliest next accept is the following edge, so back-to-back single-cycle ops issue every 2 cycles.
- Outputs are fully registered. No combinational path exists from x, y or op to any output.
- in_ready and out_valid are decoded from the state register only.
- Shift amount 0 returns x unchanged. Multiplier and counter wrap are not used: the counter stops at WIDTH−1.

## Test plan
- Reset release, then AND with x=0x4BC5, y=0x4BC7 -> result 0x4BC5, comp 100, slt 1, carry 0, out_valid exactly 1 cycle after accept.
- ADD with x=0x7FFF, y=0x0001 -> result 0x8000, overflow 1, carry 0. ADDU with x=0xFFFF, y=0x0001 -> result 0x0000, carry 1, overflow 0.
- SUB with x=0x0003, y=0x0005 -> result 0xFFFE, carry 0, overflow 0, comp 100. SLL with x=0x0001, y=0x0013 -> result 0x0008. Opcode 1111 -> result 0, err 1.
- MULU with x=0xFFFF, y=0xFFFF -> result 0x0001, result_hi 0xFFFE, out_valid exactly 16 cycles after accept. in_ready stays 0 throughout, even with in_valid held high.
- Backpressure: hold out_ready low for 5 cycles after a MULU result -> all outputs stable and in_ready 0. Raising out_ready -> in_ready 1 on the next edge.
- Pulse clear low 8 cycles into a MULU -> outputs 0 immediately and no out_valid. After release, OR with x=0x00F0, y=0x0F00 -> result 0x0FF0, latency 1.
